// File: rtl/irrigation_countdown_timer_pkg.sv
// Shared types and BCD constants for the irrigation countdown timer and its display driver.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Digit field indices within the packed MM:SS word, shared with the display driver.
    localparam int DIG_SEC_UNITS = 0;
    localparam int DIG_SEC_TENS  = 1;
    localparam int DIG_MIN_UNITS = 2;
    localparam int DIG_MIN_TENS  = 3;

    // Per-digit ceiling: both the clamp value for presets and the wrap value on borrow.
    localparam logic [3:0][3:0] DIGIT_WRAP = {UNITS_MAX, UNITS_MAX, SEC_TENS_MAX, UNITS_MAX};

    function automatic logic [3:0][3:0] sanitize_preset(input logic [15:0] preset);
        logic [3:0][3:0] digits;
        digits = preset;
        for (int i = 0; i < 4; i++) begin
            if (digits[i] > DIGIT_WRAP[i]) digits[i] = DIGIT_WRAP[i];
        end
        return digits;
    endfunction

endpackage

// File: rtl/irrigation_countdown_timer_if.sv
// Control inputs and digit/status outputs of the countdown timer, grouped for the controller side.
interface irrigation_countdown_timer_if;

    logic        load;
    logic [15:0] preset;
    logic        start;
    logic        pause;
    logic [3:0]  data_3;
    logic [3:0]  data_2;
    logic [3:0]  data_1;
    logic [3:0]  data_0;
    logic        running;
    logic        done;
    logic        done_pulse;

    modport master (
        output load, preset, start, pause,
        input  data_3, data_2, data_1, data_0, running, done, done_pulse
    );

    modport slave (
        input  load, preset, start, pause,
        output data_3, data_2, data_1, data_0, running, done, done_pulse
    );

endinterface

// File: rtl/irrigation_countdown_timer_bcd_digit_down.sv
// One stage of the BCD decrement chain: takes a borrow, wraps from 0 to the digit's ceiling.
module bcd_digit_down (
    input  logic [3:0] i_digit,
    input  logic [3:0] i_wrap,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit,
    output logic       o_borrow_out
);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        o_digit      = i_digit;
        o_borrow_out = 1'b0;
        if (i_borrow_in) begin
            if (i_digit == 4'd0) begin
                o_digit      = i_wrap;
                o_borrow_out = 1'b1;
            end else begin
                o_digit = i_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/irrigation_countdown_timer.sv
// MM:SS BCD countdown with 1 Hz prescaler, pause/resume and done strobe feeding the display mux.
module irrigation_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIVISOR = 50_000_000,
    parameter int DIV_WIDTH    = 26
) (
    input  logic                         clock,
    input  logic                         reset,
    irrigation_countdown_timer_if.slave  bus
);

    localparam logic [DIV_WIDTH-1:0] TICK_LAST = DIV_WIDTH'(TICK_DIVISOR - 1);

    state_t                r_state;
    logic [3:0][3:0]       r_count;
    logic [DIV_WIDTH-1:0]  r_presc;
    logic                  r_running;
    logic                  r_done;
    logic                  r_done_pulse;

    logic [3:0][3:0]       w_next;
    logic [4:0]            w_borrow;
    logic                  w_tick;

    assign w_borrow[0] = 1'b1;
    assign w_tick      = (r_presc == TICK_LAST);

    for (genvar g = 0; g < 4; g++) begin : g_chain
        bcd_digit_down u_digit (
            .i_digit      (r_count[g]),
            .i_wrap       (DIGIT_WRAP[g]),
            .i_borrow_in  (w_borrow[g]),
            .o_digit      (w_next[g]),
            .o_borrow_out (w_borrow[g+1])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_presc      <= '0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (bus.load) begin
                r_count   <= sanitize_preset(bus.preset);
                r_state   <= IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start && !bus.pause) begin
                            if (r_count != '0) begin
                                r_state   <= RUNNING;
                                r_presc   <= '0;
                                r_running <= 1'b1;
                            end else begin
                                r_state      <= DONE;
                                r_done       <= 1'b1;
                                r_done_pulse <= 1'b1;
                            end
                        end
                    end
                    RUNNING: begin
                        if (bus.pause) begin
                            r_state   <= PAUSED;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            // Borrow out of the top digit means the count is already 0000.
                            if (!w_borrow[4]) begin
                                r_count <= w_next;
                                if (w_next == '0) begin
                                    r_state      <= DONE;
                                    r_running    <= 1'b0;
                                    r_done       <= 1'b1;
                                    r_done_pulse <= 1'b1;
                                end
                            end
                        end else begin
                            r_presc <= r_presc + DIV_WIDTH'(1);
                        end
                    end
                    PAUSED: begin
                        if (bus.start && !bus.pause) begin
                            r_state   <= RUNNING;
                            r_running <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_3     = r_count[DIG_MIN_TENS];
    assign bus.data_2     = r_count[DIG_MIN_UNITS];
    assign bus.data_1     = r_count[DIG_SEC_TENS];
    assign bus.data_0     = r_count[DIG_SEC_UNITS];
    assign bus.running    = r_running;
    assign bus.done       = r_done;
    assign bus.done_pulse = r_done_pulse;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Directed-vector bench for irrigation_countdown_timer with a 4-cycle tick.
module tb_irrigation_countdown_timer;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    irrigation_countdown_timer_if bus ();

    irrigation_countdown_timer #(
        .TICK_DIVISOR (4),
        .DIV_WIDTH    (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    wire [15:0] w_data = {bus.data_3, bus.data_2, bus.data_1, bus.data_0};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are then sampled 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] value);
        bus.load   = 1'b1;
        bus.preset = value;
        step(1);
        bus.load   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.preset = 16'h0000;
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        step(2);
        reset = 1'b0;
        check("reset_data", w_data, 16'h0000);
        check("reset_running", 16'(bus.running), 16'h0);
        check("reset_done", 16'(bus.done), 16'h0);
        check("reset_pulse", 16'(bus.done_pulse), 16'h0);

        // Basic countdown: first decrement 4 edges after the start edge.
        do_load(16'h0012);
        do_start();
        check("run_running", 16'(bus.running), 16'h1);
        step(3);
        check("run_no_early_tick", w_data, 16'h0012);
        step(1);
        check("run_first_tick", w_data, 16'h0011);
        step(4);
        check("run_second_tick", w_data, 16'h0010);

        // Borrow through both seconds digits and minutes units.
        do_load(16'h1000);
        do_start();
        step(4);
        check("borrow_first", w_data, 16'h0959);
        step(4);
        check("borrow_second", w_data, 16'h0958);

        // Expiry after two ticks.
        do_load(16'h0002);
        do_start();
        step(4);
        check("exp_tick1", w_data, 16'h0001);
        step(3);
        check("exp_not_done_yet", 16'(bus.done), 16'h0);
        step(1);
        check("exp_data", w_data, 16'h0000);
        check("exp_done", 16'(bus.done), 16'h1);
        check("exp_pulse_high", 16'(bus.done_pulse), 16'h1);
        check("exp_running", 16'(bus.running), 16'h0);
        step(1);
        check("exp_pulse_low", 16'(bus.done_pulse), 16'h0);
        check("exp_done_held", 16'(bus.done), 16'h1);
        do_start();
        step(1);
        check("done_ignores_start_run", 16'(bus.running), 16'h0);
        check("done_ignores_start_done", 16'(bus.done), 16'h1);
        check("done_ignores_start_pulse", 16'(bus.done_pulse), 16'h0);
        do_load(16'h0005);
        check("reload_done", 16'(bus.done), 16'h0);
        check("reload_data", w_data, 16'h0005);
        check("reload_running", 16'(bus.running), 16'h0);

        // Pause after two prescaler counts, hold 10 edges, resume: two counts remain.
        do_load(16'h0003);
        do_start();
        step(2);
        bus.pause = 1'b1;
        step(1);
        check("pause_running", 16'(bus.running), 16'h0);
        step(9);
        check("pause_hold_data", w_data, 16'h0003);
        bus.pause = 1'b0;
        do_start();
        check("resume_running", 16'(bus.running), 16'h1);
        step(1);
        check("resume_no_early_tick", w_data, 16'h0003);
        step(1);
        check("resume_tick", w_data, 16'h0002);

        // Pause and start together while paused: pause wins.
        bus.pause = 1'b1;
        step(1);
        bus.start = 1'b1;
        step(2);
        check("pause_start_both", 16'(bus.running), 16'h0);
        bus.start = 1'b0;
        bus.pause = 1'b0;

        // Load with start in the same cycle; out-of-range digits are clamped.
        bus.start = 1'b1;
        do_load(16'hFA7C);
        bus.start = 1'b0;
        check("sanitize_data", w_data, 16'h9959);
        check("load_beats_start", 16'(bus.running), 16'h0);
        step(5);
        check("start_dropped", w_data, 16'h9959);

        // Start with a zero count goes straight to DONE.
        do_load(16'h0000);
        do_start();
        check("zero_done", 16'(bus.done), 16'h1);
        check("zero_pulse", 16'(bus.done_pulse), 16'h1);
        step(1);
        check("zero_pulse_low", 16'(bus.done_pulse), 16'h0);

        // Reset mid-countdown clears everything.
        do_load(16'h0012);
        do_start();
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midreset_data", w_data, 16'h0000);
        check("midreset_running", 16'(bus.running), 16'h0);
        check("midreset_done", 16'(bus.done), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
